// File: rtl/polyphase_mac_scheduler.sv
// Sequencer for a folded L/M polyphase resampler: accepts input samples, drives the
// delay-line write pointer and schedules one T-tap pass of the shared MAC per output.
module polyphase_mac_scheduler #(
  parameter int L_FACTOR       = 2,
  parameter int M_FACTOR       = 3,
  parameter int TAPS_PER_PHASE = 113,
  parameter int DEPTH_LOG2     = 7,
  parameter int COEF_AW        = $clog2(L_FACTOR * TAPS_PER_PHASE),
  parameter int PH_W           = (L_FACTOR > 1) ? $clog2(L_FACTOR) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic                  o_wr_en,
  output logic [DEPTH_LOG2-1:0] o_wr_addr,
  output logic [DEPTH_LOG2-1:0] o_rd_addr,
  output logic [COEF_AW-1:0]    o_coef_addr,
  output logic                  o_mac_en,
  output logic                  o_mac_first,
  output logic                  o_mac_last,
  output logic [PH_W-1:0]       o_phase,
  output logic                  o_busy
);

  localparam int Q      = M_FACTOR / L_FACTOR;
  localparam int R      = M_FACTOR % L_FACTOR;
  localparam int NEED_W = $clog2(Q + 2);
  localparam int TAP_W  = $clog2(TAPS_PER_PHASE);

  localparam logic [TAP_W-1:0]  TAP_LAST = TAP_W'(TAPS_PER_PHASE - 1);
  localparam logic [NEED_W-1:0] NEED_Q   = NEED_W'(Q);
  localparam logic [NEED_W-1:0] NEED_Q1  = NEED_W'(Q + 1);
  localparam logic [NEED_W-1:0] NEED_ONE = NEED_W'(1);
  localparam logic [PH_W:0]     PH_R     = (PH_W + 1)'(R);
  localparam logic [PH_W:0]     PH_L     = (PH_W + 1)'(L_FACTOR);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] newest;
  logic [PH_W-1:0]       ph;
  logic [NEED_W-1:0]     need;
  logic [TAP_W-1:0]      tap;

  logic                  run;
  logic                  accept;
  logic [PH_W:0]         ph_sum;
  logic [PH_W:0]         ph_wrap;
  logic [PH_W-1:0]       ph_next;
  logic [NEED_W-1:0]     need_next;

  // Handshake: a sample transfers on a cycle where i_valid && i_ready; i_ready
  // depends only on state and rst, and upstream holds i_valid/data until taken.
  assign run    = (state == RUN) && !rst;
  assign i_ready = (state == IDLE) && !rst;
  assign accept = i_valid && i_ready;

  // Phase advance by M per output, expressed as Q whole inputs plus R sub-phases.
  always_comb begin
    ph_sum  = {1'b0, ph} + PH_R;
    ph_wrap = ph_sum - PH_L;
    if (ph_sum >= PH_L) begin
      ph_next   = ph_wrap[PH_W-1:0];
      need_next = NEED_Q1;
    end else begin
      ph_next   = ph_sum[PH_W-1:0];
      need_next = NEED_Q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      newest <= '0;
      ph     <= '0;
      need   <= NEED_ONE;
      tap    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            newest <= wr_ptr;
            wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            need   <= need - NEED_ONE;
            if (need == NEED_ONE) begin
              state <= RUN;
              tap   <= '0;
            end
          end
        end
        RUN: begin
          if (tap == TAP_LAST) begin
            ph   <= ph_next;
            need <= need_next;
            tap  <= '0;
            // Interpolating branches chain passes without waiting for a new sample.
            if (need_next != '0) begin
              state <= IDLE;
            end
          end else begin
            tap <= tap + TAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_wr_en     = accept;
  assign o_wr_addr   = rst ? '0 : wr_ptr;
  assign o_rd_addr   = run ? (newest - DEPTH_LOG2'(tap)) : '0;
  assign o_coef_addr = run ? (COEF_AW'(ph) * COEF_AW'(TAPS_PER_PHASE) + COEF_AW'(tap)) : '0;
  assign o_mac_en    = run;
  assign o_mac_first = run && (tap == '0);
  assign o_mac_last  = run && (tap == TAP_LAST);
  assign o_phase     = run ? ph : '0;
  assign o_busy      = run;

endmodule

// File: tb/tb_polyphase_mac_scheduler.sv
// Directed bench for polyphase_mac_scheduler: one instance with default parameters
// and one interpolating instance (L=4, M=3, T=8).
module tb_polyphase_mac_scheduler;

  localparam int T_A = 113;
  localparam int T_B = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic drv_valid = 1'b0;
  int   sel = 0;

  always #5 clk = ~clk;

  logic       a_valid, a_ready, a_wr_en, a_mac_en, a_first, a_last, a_busy;
  logic [6:0] a_wr_addr, a_rd_addr;
  logic [7:0] a_coef;
  logic [0:0] a_phase;

  logic       b_valid, b_ready, b_wr_en, b_mac_en, b_first, b_last, b_busy;
  logic [3:0] b_wr_addr, b_rd_addr;
  logic [4:0] b_coef;
  logic [1:0] b_phase;

  assign a_valid = drv_valid && (sel == 0);
  assign b_valid = drv_valid && (sel == 1);

  polyphase_mac_scheduler u_dut_a (
    .clk(clk), .rst(rst), .i_valid(a_valid), .i_ready(a_ready),
    .o_wr_en(a_wr_en), .o_wr_addr(a_wr_addr), .o_rd_addr(a_rd_addr),
    .o_coef_addr(a_coef), .o_mac_en(a_mac_en), .o_mac_first(a_first),
    .o_mac_last(a_last), .o_phase(a_phase), .o_busy(a_busy)
  );

  polyphase_mac_scheduler #(
    .L_FACTOR(4), .M_FACTOR(3), .TAPS_PER_PHASE(T_B), .DEPTH_LOG2(4)
  ) u_dut_b (
    .clk(clk), .rst(rst), .i_valid(b_valid), .i_ready(b_ready),
    .o_wr_en(b_wr_en), .o_wr_addr(b_wr_addr), .o_rd_addr(b_rd_addr),
    .o_coef_addr(b_coef), .o_mac_en(b_mac_en), .o_mac_first(b_first),
    .o_mac_last(b_last), .o_phase(b_phase), .o_busy(b_busy)
  );

  // Selected-instance view so sequences can be shared between the two DUTs.
  logic       s_ready, s_wr_en, s_mac_en, s_first, s_last, s_busy;
  logic [7:0] s_wr_addr, s_rd_addr, s_coef;
  logic [3:0] s_phase;

  always_comb begin
    if (sel == 0) begin
      s_ready = a_ready; s_wr_en = a_wr_en; s_mac_en = a_mac_en;
      s_first = a_first; s_last = a_last; s_busy = a_busy;
      s_wr_addr = {1'b0, a_wr_addr}; s_rd_addr = {1'b0, a_rd_addr};
      s_coef = a_coef; s_phase = {3'b0, a_phase};
    end else begin
      s_ready = b_ready; s_wr_en = b_wr_en; s_mac_en = b_mac_en;
      s_first = b_first; s_last = b_last; s_busy = b_busy;
      s_wr_addr = {4'b0, b_wr_addr}; s_rd_addr = {4'b0, b_rd_addr};
      s_coef = {3'b0, b_coef}; s_phase = {2'b0, b_phase};
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_cnt = 0;

  always @(negedge clk) begin
    if (sel == 0 && a_last === 1'b1) last_cnt++;
  end

  typedef struct {
    int sel;
    int wr_addr;
    int n_pass;
    int ph0;
    int ph1;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    drv_valid = 1'b0;
    repeat (cycles) tick();
    rst = 1'b0;
    #1;
  endtask

  // Walks one full pass starting at its first tap; leaves the bench one cycle after o_mac_last.
  task automatic run_pass(input int t, input int mask, input int phase,
                          input int rd_base, input int wr_hold);
    for (int k = 0; k < t; k++) begin
      chk("mac_en", {31'b0, s_mac_en}, 1);
      chk("mac_first", {31'b0, s_first}, (k == 0) ? 1 : 0);
      chk("mac_last", {31'b0, s_last}, (k == t - 1) ? 1 : 0);
      chk("phase", {28'b0, s_phase}, phase);
      chk("coef_addr", {24'b0, s_coef}, phase * t + k);
      chk("rd_addr", {24'b0, s_rd_addr}, (rd_base - k) & mask);
      chk("ready_in_pass", {31'b0, s_ready}, 0);
      chk("wr_en_in_pass", {31'b0, s_wr_en}, 0);
      chk("wr_addr_hold", {24'b0, s_wr_addr}, wr_hold);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, mask, count, cycles, snap;

    vecs[0] = '{0, 0, 1, 0, 0};
    vecs[1] = '{0, 1, 1, 1, 0};
    vecs[2] = '{0, 2, 0, 0, 0};
    vecs[3] = '{0, 3, 1, 0, 0};
    vecs[4] = '{0, 4, 1, 1, 0};
    vecs[5] = '{0, 5, 0, 0, 0};
    vecs[6] = '{1, 0, 2, 0, 3};
    vecs[7] = '{1, 1, 1, 2, 0};
    vecs[8] = '{1, 2, 1, 1, 0};
    vecs[9] = '{1, 3, 2, 0, 3};

    // Reset: outputs quiet while rst is high even with a sample offered.
    sel = 0;
    rst = 1'b1;
    drv_valid = 1'b1;
    tick();
    tick();
    chk("rst_ready", {31'b0, s_ready}, 0);
    chk("rst_wr_en", {31'b0, s_wr_en}, 0);
    chk("rst_busy", {31'b0, s_busy}, 0);
    chk("rst_mac_en", {31'b0, s_mac_en}, 0);
    chk("rst_wr_addr", {24'b0, s_wr_addr}, 0);
    drv_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, s_ready}, 1);
    chk("post_rst_busy", {31'b0, s_busy}, 0);

    // Single sample: phase-0 pass, then the next sample runs phase 1 immediately.
    drv_valid = 1'b1;
    #1;
    chk("single_accept", {31'b0, s_wr_en}, 1);
    chk("single_wr_addr", {24'b0, s_wr_addr}, 0);
    tick();
    drv_valid = 1'b0;
    run_pass(T_A, 127, 0, 0, 1);
    chk("single_ready_after", {31'b0, s_ready}, 1);
    chk("single_busy_after", {31'b0, s_busy}, 0);
    chk("single_mac_en_after", {31'b0, s_mac_en}, 0);
    drv_valid = 1'b1;
    #1;
    chk("second_accept", {31'b0, s_wr_en}, 1);
    chk("second_wr_addr", {24'b0, s_wr_addr}, 1);
    tick();
    drv_valid = 1'b0;
    run_pass(T_A, 127, 1, 1, 2);

    // Table: continuous i_valid; every record must be accepted on the cycle reached.
    sel = -1;
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].sel != sel) begin
        do_reset(2);
        sel = vecs[i].sel;
        drv_valid = 1'b1;
        #1;
      end
      t = (sel == 0) ? T_A : T_B;
      mask = (sel == 0) ? 127 : 15;
      chk("vec_accept", {31'b0, s_wr_en}, 1);
      chk("vec_busy_idle", {31'b0, s_busy}, 0);
      chk("vec_wr_addr", {24'b0, s_wr_addr}, vecs[i].wr_addr);
      tick();
      for (int p = 0; p < vecs[i].n_pass; p++) begin
        run_pass(t, mask, (p == 0) ? vecs[i].ph0 : vecs[i].ph1,
                 vecs[i].wr_addr, (vecs[i].wr_addr + 1) & mask);
      end
    end
    drv_valid = 1'b0;

    // Wrap: the 130th accepted sample lands at address 1 and reads back across 0.
    do_reset(2);
    sel = 0;
    drv_valid = 1'b1;
    #1;
    count = 0;
    cycles = 0;
    while (cycles < 30000) begin
      if (s_wr_en === 1'b1) count++;
      if (count == 130) break;
      tick();
      cycles++;
    end
    chk("wrap_accepts", count, 130);
    chk("wrap_wr_addr", {24'b0, s_wr_addr}, 1);
    tick();
    drv_valid = 1'b0;
    run_pass(T_A, 127, 0, 1, 2);

    // Reset in the middle of a pass at tap 50.
    do_reset(2);
    drv_valid = 1'b1;
    #1;
    chk("mid_accept", {31'b0, s_wr_en}, 1);
    tick();
    drv_valid = 1'b0;
    repeat (50) tick();
    chk("mid_tap50_coef", {24'b0, s_coef}, 50);
    snap = last_cnt;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, s_busy}, 0);
    chk("mid_rst_mac_en", {31'b0, s_mac_en}, 0);
    chk("mid_rst_ready", {31'b0, s_ready}, 0);
    chk("mid_rst_coef", {24'b0, s_coef}, 0);
    tick();
    chk("mid_rst_hold_busy", {31'b0, s_busy}, 0);
    chk("mid_rst_hold_last", {31'b0, s_last}, 0);
    rst = 1'b0;
    #1;
    chk("mid_post_ready", {31'b0, s_ready}, 1);
    chk("mid_post_wr_addr", {24'b0, s_wr_addr}, 0);
    repeat (70) tick();
    chk("mid_no_stray_last", last_cnt - snap, 0);
    chk("mid_idle_busy", {31'b0, s_busy}, 0);
    drv_valid = 1'b1;
    #1;
    chk("mid_next_accept", {31'b0, s_wr_en}, 1);
    chk("mid_next_wr_addr", {24'b0, s_wr_addr}, 0);
    tick();
    drv_valid = 1'b0;
    run_pass(T_A, 127, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
